// File: rtl/i2s_audio_mixer.sv
// Multi-source stereo mixer with per-source 4-bit gain and saturation, feeding
// an I2S serialiser. The mix is computed once per frame from a snapshot of the hold registers.
module i2s_audio_mixer #(
    parameter int NUM_SRC   = 2,
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_HALF = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*SAMPLE_W-1:0] src_l_i,
    input  logic [NUM_SRC*SAMPLE_W-1:0] src_r_i,
    input  logic [NUM_SRC-1:0]          src_valid_i,
    input  logic [NUM_SRC*4-1:0]        vol_i,
    output logic [SAMPLE_W-1:0]         mix_l_o,
    output logic [SAMPLE_W-1:0]         mix_r_o,
    output logic                        clip_o,
    output logic                        frame_o,
    output logic                        bclk_o,
    output logic                        lrck_o,
    output logic                        dacdat_o
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int CDIV_W     = $clog2(BCLK_HALF);
    localparam int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SEL_W      = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam int ACC_W      = SAMPLE_W + 4 + $clog2(NUM_SRC) + 1;
    localparam int PROD_W     = SAMPLE_W + 5;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_SAT} state_t;

    // ---------------- clocking / serialiser ----------------
    logic [CDIV_W-1:0]   r_cdiv;
    logic                r_bclk;
    logic [BIT_W-1:0]    r_bitcnt;
    logic                r_frame;
    logic                r_dacdat;
    logic [SAMPLE_W-1:0] r_out_l;
    logic [SAMPLE_W-1:0] r_out_r;
    logic [SAMPLE_W-1:0] r_mix_l;
    logic [SAMPLE_W-1:0] r_mix_r;
    logic                r_clip;

    logic                w_wrap;
    logic                w_fall;
    logic                w_last_bit;
    logic                w_frame_evt;
    logic [BIT_W-1:0]    w_bitcnt_nxt;
    logic                w_right;
    logic [BIT_W-1:0]    w_p;
    logic [SAMPLE_W-1:0] w_word;
    logic [SEL_W-1:0]    w_sel;
    logic                w_dat_nxt;

    assign w_wrap      = (r_cdiv == CDIV_W'(BCLK_HALF - 1));
    assign w_fall      = w_wrap & r_bclk;
    assign w_last_bit  = (r_bitcnt == BIT_W'(FRAME_BITS - 1));
    assign w_frame_evt = w_fall & w_last_bit;

    // Serial bit for the slot position the falling edge is about to enter.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_bitcnt_nxt = w_last_bit ? '0 : r_bitcnt + BIT_W'(1);
        w_right      = (w_bitcnt_nxt >= BIT_W'(SLOT_BITS));
        w_p          = w_right ? w_bitcnt_nxt - BIT_W'(SLOT_BITS) : w_bitcnt_nxt;
        w_word       = w_right ? r_out_r : r_out_l;
        w_sel        = SEL_W'(BIT_W'(SAMPLE_W) - w_p);
        w_dat_nxt    = 1'b0;
        if ((w_p != '0) && (w_p <= BIT_W'(SAMPLE_W)))
            w_dat_nxt = w_word[w_sel];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cdiv   <= '0;
            r_bclk   <= 1'b0;
            r_bitcnt <= '0;
            r_frame  <= 1'b0;
            r_dacdat <= 1'b0;
            r_out_l  <= '0;
            r_out_r  <= '0;
        end else begin
            r_frame <= 1'b0;
            if (w_wrap) begin
                r_cdiv <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_cdiv <= r_cdiv + CDIV_W'(1);
            end
            if (w_fall) begin
                r_bitcnt <= w_bitcnt_nxt;
                r_dacdat <= w_dat_nxt;
            end
            if (w_frame_evt) begin
                r_frame <= 1'b1;
                r_out_l <= r_mix_l;
                r_out_r <= r_mix_r;
            end
        end
    end

    // ---------------- hold and snapshot registers ----------------
    logic [SAMPLE_W-1:0] r_hold_l [NUM_SRC];
    logic [SAMPLE_W-1:0] r_hold_r [NUM_SRC];
    logic [SAMPLE_W-1:0] r_snap_l [NUM_SRC];
    logic [SAMPLE_W-1:0] r_snap_r [NUM_SRC];

    // NOTE: these small arrays are flops, not RAM, and must read 0 after reset,
    // so they are cleared in the reset branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_hold_l[i] <= '0;
                r_hold_r[i] <= '0;
                r_snap_l[i] <= '0;
                r_snap_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid_i[i]) begin
                    r_hold_l[i] <= src_l_i[i*SAMPLE_W +: SAMPLE_W];
                    r_hold_r[i] <= src_r_i[i*SAMPLE_W +: SAMPLE_W];
                end
                if (w_frame_evt) begin
                    r_snap_l[i] <= r_hold_l[i];
                    r_snap_r[i] <= r_hold_r[i];
                end
            end
        end
    end

    // ---------------- mixer FSM ----------------
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic signed [ACC_W-1:0]  r_acc_l;
    logic signed [ACC_W-1:0]  r_acc_r;

    logic [3:0]               w_vol;
    logic [SAMPLE_W-1:0]      w_s_l;
    logic [SAMPLE_W-1:0]      w_s_r;
    logic signed [PROD_W-1:0] w_prod_l;
    logic signed [PROD_W-1:0] w_prod_r;
    logic signed [ACC_W-1:0]  w_sh_l;
    logic signed [ACC_W-1:0]  w_sh_r;
    logic                     w_hi_l, w_lo_l, w_hi_r, w_lo_r;
    logic [SAMPLE_W-1:0]      w_sat_l;
    logic [SAMPLE_W-1:0]      w_sat_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_frame) w_state_nxt = ST_ACC;
            ST_ACC:  if (r_idx == IDX_W'(NUM_SRC - 1)) w_state_nxt = ST_SAT;
            ST_SAT:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gain is signed sample times unsigned 0..15; both operands widened to PROD_W.
    assign w_vol    = vol_i[4*r_idx +: 4];
    assign w_s_l    = r_snap_l[r_idx];
    assign w_s_r    = r_snap_r[r_idx];
    assign w_prod_l = $signed({{5{w_s_l[SAMPLE_W-1]}}, w_s_l}) *
                      $signed({{(SAMPLE_W+1){1'b0}}, w_vol});
    assign w_prod_r = $signed({{5{w_s_r[SAMPLE_W-1]}}, w_s_r}) *
                      $signed({{(SAMPLE_W+1){1'b0}}, w_vol});

    // Unity gain is 8, so the sum is scaled back by an arithmetic (flooring) shift.
    assign w_sh_l  = r_acc_l >>> 3;
    assign w_sh_r  = r_acc_r >>> 3;
    assign w_hi_l  = (w_sh_l > SAT_MAX);
    assign w_lo_l  = (w_sh_l < SAT_MIN);
    assign w_hi_r  = (w_sh_r > SAT_MAX);
    assign w_lo_r  = (w_sh_r < SAT_MIN);
    assign w_sat_l = w_hi_l ? SAT_MAX[SAMPLE_W-1:0] :
                     w_lo_l ? SAT_MIN[SAMPLE_W-1:0] : w_sh_l[SAMPLE_W-1:0];
    assign w_sat_r = w_hi_r ? SAT_MAX[SAMPLE_W-1:0] :
                     w_lo_r ? SAT_MIN[SAMPLE_W-1:0] : w_sh_r[SAMPLE_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_mix_l <= '0;
            r_mix_r <= '0;
            r_clip  <= 1'b0;
        end else begin
            r_clip <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_frame) begin
                        r_idx   <= '0;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                    end
                end
                ST_ACC: begin
                    r_acc_l <= r_acc_l + ACC_W'(w_prod_l);
                    r_acc_r <= r_acc_r + ACC_W'(w_prod_r);
                    r_idx   <= r_idx + IDX_W'(1);
                end
                ST_SAT: begin
                    r_mix_l <= w_sat_l;
                    r_mix_r <= w_sat_r;
                    r_clip  <= w_hi_l | w_lo_l | w_hi_r | w_lo_r;
                end
                default: ;
            endcase
        end
    end

    assign mix_l_o  = r_mix_l;
    assign mix_r_o  = r_mix_r;
    assign clip_o   = r_clip;
    assign frame_o  = r_frame;
    assign bclk_o   = r_bclk;
    assign lrck_o   = (r_bitcnt >= BIT_W'(SLOT_BITS));
    assign dacdat_o = r_dacdat;

endmodule
